// File: rtl/ad9228_window_capture.sv
// Per-channel triggered window capture behind the AD9228 gearbox: pre-trigger ring, rising-edge trigger, stream readout.
// Define AD9228_SIGNED_SAMPLES_EN to compare samples against the threshold as two's complement.
module ad9228_window_capture #(
  parameter  int DATA_WIDTH = 12,
  parameter  int DEPTH      = 64,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  dco,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid_in,
  input  logic                  arm,
  input  logic [DATA_WIDTH-1:0] threshold,
  input  logic [ADDR_W-1:0]     pre_samples,
  input  logic [ADDR_W-1:0]     post_samples,
  output logic                  trig_out,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_W   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WAIT_TRIG,
    S_POST,
    S_READOUT
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  valid_d;
  logic                  strb;
  logic [DATA_WIDTH-1:0] thr_q;
  logic [ADDR_W-1:0]     pre_q, post_q;
  logic                  below;
  logic [ADDR_W-1:0]     wr_ptr, rd_ptr, trig_addr, rd_base;
  logic [ADDR_W-1:0]     cnt;
  logic [ADDR_W:0]       cnt_inc;
  logic [ADDR_W:0]       remaining;
  logic [ADDR_W-1:0]     post_eff, post_lim;
  logic [ADDR_W:0]       cfg_sum;
  logic                  accept, trig_hit, load, enter_readout;

  function automatic logic ge_thr(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
`ifdef AD9228_SIGNED_SAMPLES_EN
    return ($signed(a) >= $signed(b));
`else
    return (a >= b);
`endif
  endfunction

  // Gearbox valid is a level; only its rising edge marks a new word.
  assign strb     = sample_valid_in & ~valid_d;
  assign cnt_inc  = {1'b0, cnt} + ONE_W;
  assign accept   = strb & ((state == S_FILL) | (state == S_WAIT_TRIG) | (state == S_POST));
  assign trig_hit = strb & (state == S_WAIT_TRIG) & below & ge_thr(sample_in, thr_q);
  assign load     = (state == S_READOUT) & (remaining != '0) & (~m_valid | m_ready);
  assign rd_base  = (state == S_WAIT_TRIG) ? wr_ptr : trig_addr;
  assign enter_readout = (state != S_READOUT) & (state_nxt == S_READOUT);

  // Post count is at least one and the whole window never exceeds the ring.
  always_comb begin
    post_eff = (post_samples == '0) ? ONE_A : post_samples;
    cfg_sum  = {1'b0, pre_samples} + {1'b0, post_eff};
    post_lim = (cfg_sum > DEPTH_W) ? ADDR_W'(DEPTH_W - {1'b0, pre_samples}) : post_eff;
  end

  always_ff @(posedge dco or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (arm) state_nxt = (pre_samples == '0) ? S_WAIT_TRIG : S_FILL;
      S_FILL:      if (strb && (cnt_inc == {1'b0, pre_q})) state_nxt = S_WAIT_TRIG;
      S_WAIT_TRIG: if (trig_hit) state_nxt = (post_q == ONE_A) ? S_READOUT : S_POST;
      S_POST:      if (strb && (cnt_inc == {1'b0, post_q})) state_nxt = S_READOUT;
      S_READOUT:   if (m_valid && m_ready && m_last) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

  always_ff @(posedge dco) begin
    if (accept) mem[wr_ptr] <= sample_in;
  end

  // The output register doubles as the RAM read register; it only reloads when empty or being drained.
  always_ff @(posedge dco or posedge rst) begin
    if (rst) begin
      valid_d   <= 1'b0;
      trig_out  <= 1'b0;
      thr_q     <= '0;
      pre_q     <= '0;
      post_q    <= '0;
      below     <= 1'b0;
      cnt       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      trig_addr <= '0;
      remaining <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
    end else begin
      valid_d  <= sample_valid_in;
      trig_out <= trig_hit;
      if ((state == S_IDLE) && arm) begin
        thr_q  <= threshold;
        pre_q  <= pre_samples;
        post_q <= post_lim;
        below  <= 1'b0;
        cnt    <= '0;
      end
      if (accept) begin
        wr_ptr <= wr_ptr + ONE_A;
        below  <= ~ge_thr(sample_in, thr_q);
        cnt    <= cnt + ONE_A;
      end
      if (trig_hit) begin
        trig_addr <= wr_ptr;
        cnt       <= ONE_A;
      end
      if (enter_readout) begin
        rd_ptr    <= rd_base - pre_q;
        remaining <= {1'b0, pre_q} + {1'b0, post_q};
      end
      if (load) begin
        m_data    <= mem[rd_ptr];
        m_valid   <= 1'b1;
        m_last    <= (remaining == ONE_W);
        rd_ptr    <= rd_ptr + ONE_A;
        remaining <= remaining - ONE_W;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ad9228_window_capture.sv
// Directed bench for ad9228_window_capture: strobe qualification, backpressure, ring wrap, clamp, reset, signed compare.
module tb_ad9228_window_capture;

  localparam int DW = 12;
  localparam int AW = 6;

`ifdef AD9228_SIGNED_SAMPLES_EN
  localparam int T6_TRIGS = 1;
  localparam int T6_COUNT = 2;
  localparam int T6_D0    = 16;
  localparam int T6_D1    = 32;
  localparam int T6_BUSY  = 0;
`else
  localparam int T6_TRIGS = 0;
  localparam int T6_COUNT = 0;
  localparam int T6_D0    = 12'hFFF;
  localparam int T6_D1    = 12'hFFF;
  localparam int T6_BUSY  = 1;
`endif

  logic          dco = 1'b0;
  logic          rst;
  logic [DW-1:0] sample_in;
  logic          sample_valid_in;
  logic          arm;
  logic [DW-1:0] threshold;
  logic [AW-1:0] pre_samples;
  logic [AW-1:0] post_samples;
  logic          trig_out;
  logic          busy;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;

  int errors = 0;
  int checks = 0;
  int trig_count;
  int trig_sample;
  int trig_first;
  int rx_count, last_count, stall_bad, stall_seen;
  int win_done;
  logic [DW-1:0] rx [64];
  logic          rx_last [64];

  ad9228_window_capture #(.DATA_WIDTH(DW), .DEPTH(64)) dut (
    .dco             (dco),
    .rst             (rst),
    .sample_in       (sample_in),
    .sample_valid_in (sample_valid_in),
    .arm             (arm),
    .threshold       (threshold),
    .pre_samples     (pre_samples),
    .post_samples    (post_samples),
    .trig_out        (trig_out),
    .busy            (busy),
    .m_data          (m_data),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_last          (m_last)
  );

  always #5 dco = ~dco;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One gearbox word: valid held for 'hold' cycles then dropped for one cycle.
  task automatic applyStimulus(input logic [DW-1:0] value, input int hold);
    sample_in       = value;
    sample_valid_in = 1'b1;
    for (int c = 0; c < hold; c++) begin
      @(negedge dco);
      if (trig_out === 1'b1) begin
        trig_count++;
        trig_sample = int'(value);
        if (c == 0) trig_first = 1;
      end
    end
    sample_valid_in = 1'b0;
    @(negedge dco);
    if (trig_out === 1'b1) trig_count++;
  endtask

  task automatic feedRamp(input int start, input int n, input int hold);
    for (int k = 0; k < n; k++) applyStimulus(DW'(start + k), hold);
  endtask

  task automatic armCapture(input int thr, input int pre, input int post);
    threshold    = DW'(thr);
    pre_samples  = AW'(pre);
    post_samples = AW'(post);
    arm          = 1'b1;
    @(negedge dco);
    arm          = 1'b0;
    trig_count   = 0;
    trig_sample  = -1;
    trig_first   = 0;
  endtask

  task automatic collectWindow(input int mode, input int budget);
    logic          rdy;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    rx_count = 0; last_count = 0; stall_bad = 0; stall_seen = 0; win_done = 0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    for (int i = 0; i < 64; i++) begin
      rx[i] = '1;
      rx_last[i] = 1'b0;
    end
    for (int cyc = 0; cyc < budget && win_done == 0; cyc++) begin
      if (prev_stall) begin
        stall_seen++;
        if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) stall_bad++;
      end
      rdy = (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
      m_ready = rdy;
      if (m_valid === 1'b1 && rdy) begin
        if (rx_count < 64) begin
          rx[rx_count]      = m_data;
          rx_last[rx_count] = m_last;
        end
        rx_count++;
        if (m_last === 1'b1) begin
          last_count++;
          win_done = 1;
        end
      end
      prev_stall = (m_valid === 1'b1) && !rdy;
      prev_data  = m_data;
      prev_last  = m_last;
      @(negedge dco);
    end
    m_ready = 1'b0;
  endtask

  task automatic checkWindow(input string tag, input int base, input int n);
    checkOutput({tag, " done"}, 32'(win_done), 1);
    checkOutput({tag, " count"}, 32'(rx_count), 32'(n));
    for (int i = 0; i < n; i++) checkOutput($sformatf("%s data[%0d]", tag, i), 32'(rx[i]), 32'(base + i));
    checkOutput({tag, " last count"}, 32'(last_count), 1);
    checkOutput({tag, " last flag"}, 32'(rx_last[n-1]), 1);
    checkOutput({tag, " idle after"}, 32'(busy), 0);
    checkOutput({tag, " valid after"}, 32'(m_valid), 0);
  endtask

  initial begin
    rst = 1'b1; sample_in = '0; sample_valid_in = 1'b0; arm = 1'b0;
    threshold = '0; pre_samples = '0; post_samples = '0; m_ready = 1'b0;
    trig_count = 0; trig_sample = -1; trig_first = 0;
    repeat (2) @(negedge dco);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset m_valid", 32'(m_valid), 0);
    checkOutput("reset trig_out", 32'(trig_out), 0);
    checkOutput("reset m_last", 32'(m_last), 0);
    checkOutput("reset m_data", 32'(m_data), 0);
    rst = 1'b0;
    @(negedge dco);

    $display("[TB] test 1: strobe qualification");
    armCapture(10, 4, 4);
    checkOutput("t1 busy after arm", 32'(busy), 1);
    feedRamp(0, 14, 4);
    checkOutput("t1 trig count", 32'(trig_count), 1);
    checkOutput("t1 trig sample", 32'(trig_sample), 10);
    checkOutput("t1 trig timing", 32'(trig_first), 1);
    collectWindow(0, 200);
    checkWindow("t1", 6, 8);

    $display("[TB] test 2: backpressure and ignored re-arm");
    armCapture(10, 4, 4);
    feedRamp(0, 6, 4);
    threshold = 12'd5; pre_samples = 6'd1; post_samples = 6'd1; arm = 1'b1;
    @(negedge dco);
    arm = 1'b0;
    feedRamp(6, 8, 4);
    checkOutput("t2 trig count", 32'(trig_count), 1);
    checkOutput("t2 trig sample", 32'(trig_sample), 10);
    collectWindow(1, 200);
    checkWindow("t2", 6, 8);
    checkOutput("t2 stalls seen", 32'(stall_seen > 0), 1);
    checkOutput("t2 stall stability", 32'(stall_bad), 0);

    $display("[TB] test 3: ring wrap");
    armCapture(100, 40, 24);
    feedRamp(0, 124, 1);
    checkOutput("t3 trig count", 32'(trig_count), 1);
    checkOutput("t3 trig sample", 32'(trig_sample), 100);
    collectWindow(0, 300);
    checkWindow("t3", 60, 64);

    $display("[TB] test 4: post clamp and rising crossing");
    armCapture(100, 63, 10);
    for (int k = 0; k < 66; k++) applyStimulus(12'd200, 1);
    checkOutput("t4 no trig while high", 32'(trig_count), 0);
    applyStimulus(12'd50, 1);
    checkOutput("t4 no trig on dip", 32'(trig_count), 0);
    applyStimulus(12'd150, 1);
    checkOutput("t4 trig count", 32'(trig_count), 1);
    checkOutput("t4 trig sample", 32'(trig_sample), 150);
    checkOutput("t4 valid latency", 32'(m_valid), 1);
    collectWindow(0, 300);
    checkOutput("t4 done", 32'(win_done), 1);
    checkOutput("t4 count", 32'(rx_count), 64);
    checkOutput("t4 data[0]", 32'(rx[0]), 200);
    checkOutput("t4 data[61]", 32'(rx[61]), 200);
    checkOutput("t4 data[62]", 32'(rx[62]), 50);
    checkOutput("t4 data[63]", 32'(rx[63]), 150);
    checkOutput("t4 last flag", 32'(rx_last[63]), 1);
    checkOutput("t4 last count", 32'(last_count), 1);

    $display("[TB] test 5: reset mid-operation");
    armCapture(10, 4, 4);
    feedRamp(0, 10, 1);
    sample_in = 12'd10; sample_valid_in = 1'b1;
    @(negedge dco);
    checkOutput("t5a trig high", 32'(trig_out), 1);
    checkOutput("t5a busy before", 32'(busy), 1);
    rst = 1'b1;
    #1;
    checkOutput("t5a trig dropped", 32'(trig_out), 0);
    checkOutput("t5a busy dropped", 32'(busy), 0);
    checkOutput("t5a valid low", 32'(m_valid), 0);
    @(negedge dco);
    rst = 1'b0; sample_valid_in = 1'b0;
    @(negedge dco);
    armCapture(10, 4, 4);
    feedRamp(0, 14, 1);
    @(negedge dco);
    checkOutput("t5b valid before", 32'(m_valid), 1);
    rst = 1'b1;
    #1;
    checkOutput("t5b valid dropped", 32'(m_valid), 0);
    checkOutput("t5b busy dropped", 32'(busy), 0);
    checkOutput("t5b last dropped", 32'(m_last), 0);
    @(negedge dco);
    rst = 1'b0;
    @(negedge dco);
    armCapture(10, 4, 4);
    feedRamp(0, 14, 1);
    checkOutput("t5c trig count", 32'(trig_count), 1);
    collectWindow(0, 200);
    checkWindow("t5c", 6, 8);

    $display("[TB] test 6: threshold compare signedness");
    armCapture(0, 0, 2);
    applyStimulus(12'hF00, 1);
    applyStimulus(12'h010, 1);
    applyStimulus(12'h020, 1);
    checkOutput("t6 trig count", 32'(trig_count), 32'(T6_TRIGS));
    collectWindow(0, 20);
    checkOutput("t6 count", 32'(rx_count), 32'(T6_COUNT));
    checkOutput("t6 data[0]", 32'(rx[0]), 32'(T6_D0));
    checkOutput("t6 data[1]", 32'(rx[1]), 32'(T6_D1));
    checkOutput("t6 busy", 32'(busy), 32'(T6_BUSY));
    rst = 1'b1;
    @(negedge dco);
    rst = 1'b0;
    @(negedge dco);
    checkOutput("final idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
